exec_muldiv_unit: RTL and testbench

//  Parametrised multi-cycle RV32M/RV64M multiply/divide unit for the execute stage. Accepts one op
//  via valid/ready, iterates (multiplier MUL_RADIX_BITS per cycle, divider 1 bit/cycle), returns

---
 rtl/exec_muldiv_unit_pkg.sv | 44 ++++
 rtl/muldiv_div_iter.sv | 24 ++
 rtl/exec_muldiv_unit.sv | 206 ++++++++++++++++++++
 tb/tb_exec_muldiv_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_muldiv_unit_pkg.sv
// Shared types for the multi-cycle multiply/divide unit: operation codes, FSM states
// and small decode helpers used by the unit and its bench.
package exec_muldiv_unit_pkg;

    typedef enum logic [2:0] {
        CODE_MUL    = 3'd0,
        CODE_MULH   = 3'd1,
        CODE_MULHSU = 3'd2,
        CODE_MULHU  = 3'd3,
        CODE_DIV    = 3'd4,
        CODE_DIVU   = 3'd5,
        CODE_REM    = 3'd6,
        CODE_REMU   = 3'd7
    } muldiv_code_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_t;

    // Returns {op1_signed, op2_signed}; MUL low half is sign-agnostic so it runs unsigned.
    function automatic logic [1:0] is_signed_op(input muldiv_code_t code);
        logic [1:0] sgn;
        case (code)
            CODE_MULH:           sgn = 2'b11;
            CODE_MULHSU:         sgn = 2'b10;
            CODE_DIV, CODE_REM:  sgn = 2'b11;
            default:             sgn = 2'b00;
        endcase
        return sgn;
    endfunction

    function automatic logic is_div_op(input muldiv_code_t code);
        return (code == CODE_DIV) || (code == CODE_DIVU) ||
               (code == CODE_REM) || (code == CODE_REMU);
    endfunction

    function automatic logic is_rem_op(input muldiv_code_t code);
        return (code == CODE_REM) || (code == CODE_REMU);
    endfunction

endpackage

// File: rtl/muldiv_div_iter.sv
// One restoring-division step: shift the next dividend bit into the partial remainder,
// subtract the divisor if it fits and shift the resulting quotient bit in.
module muldiv_div_iter #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quot,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quot
);

    logic [XLEN:0] w_rem_sh;
    logic [XLEN:0] w_diff;

    // i_rem < divisor always holds, so the shifted value fits in XLEN+1 bits and the
    // top bit of the difference is a clean borrow flag.
    assign w_rem_sh = {i_rem, i_quot[XLEN-1]};
    assign w_diff   = w_rem_sh - {1'b0, i_divisor};

    assign o_rem  = w_diff[XLEN] ? w_rem_sh[XLEN-1:0] : w_diff[XLEN-1:0];
    assign o_quot = {i_quot[XLEN-2:0], ~w_diff[XLEN]};

endmodule

// File: rtl/exec_muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit: radix-2^MUL_RADIX_BITS shift-add multiplier,
// 1 bit/cycle restoring divider, magnitude datapath with sign fix-up on entry to DONE.
module exec_muldiv_unit
    import exec_muldiv_unit_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int MUL_RADIX_BITS = 2,
    parameter int TAG_W          = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_code,
    input  logic [XLEN-1:0]  req_op1,
    input  logic [XLEN-1:0]  req_op2,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_result,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int R         = MUL_RADIX_BITS;
    localparam int CNT_W     = $clog2(XLEN) + 1;
    localparam int MUL_ITERS = XLEN / MUL_RADIX_BITS;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits on ready, and resp_* stay stable while resp_valid & !resp_ready.
    // flush beats both: a request seen with flush is not accepted, a response seen with
    // flush is not consumed.

    muldiv_state_t          r_state;
    muldiv_state_t          w_next_state;
    muldiv_code_t           r_code;
    logic [TAG_W-1:0]       r_tag;
    logic                   r_neg;
    logic [XLEN-1:0]        r_a;
    logic [2*XLEN-1:0]      r_acc;
    logic [CNT_W-1:0]       r_cnt;
    logic [XLEN-1:0]        r_result;

    muldiv_code_t           w_req_code;
    logic                   w_accept;
    logic [1:0]             w_sgn;
    logic                   w_op1_neg;
    logic                   w_op2_neg;
    logic [XLEN-1:0]        w_op1_mag;
    logic [XLEN-1:0]        w_op2_mag;
    logic                   w_req_div;
    logic                   w_req_rem;
    logic                   w_div_zero;
    logic                   w_div_ovf;
    logic                   w_special;
    logic [XLEN-1:0]        w_special_result;
    logic                   w_last;

    logic [R-1:0]           w_digit;
    logic [XLEN+R-1:0]      w_pp;
    logic [XLEN+R-1:0]      w_sum;
    logic [2*XLEN-1:0]      w_mul_acc_next;
    logic [2*XLEN-1:0]      w_prod_fix;
    logic [XLEN-1:0]        w_mul_res;

    logic [XLEN-1:0]        w_div_rem;
    logic [XLEN-1:0]        w_div_quot;
    logic [XLEN-1:0]        w_div_raw;
    logic [XLEN-1:0]        w_div_res;

    // Request decode; only meaningful when w_accept, so X on idle inputs never reaches state.
    assign w_req_code = muldiv_code_t'(req_code);
    assign w_accept   = req_valid & req_ready & ~flush;
    assign w_sgn      = is_signed_op(w_req_code);
    assign w_op1_neg  = w_sgn[1] & req_op1[XLEN-1];
    assign w_op2_neg  = w_sgn[0] & req_op2[XLEN-1];
    assign w_op1_mag  = w_op1_neg ? -req_op1 : req_op1;
    assign w_op2_mag  = w_op2_neg ? -req_op2 : req_op2;
    assign w_req_div  = is_div_op(w_req_code);
    assign w_req_rem  = is_rem_op(w_req_code);
    assign w_div_zero = (req_op2 == '0);
    assign w_div_ovf  = w_sgn[1] & (req_op1 == {1'b1, {(XLEN-1){1'b0}}}) & (req_op2 == '1);
    assign w_special  = w_req_div & (w_div_zero | w_div_ovf);

    always_comb begin
        w_special_result = '0;
        if (w_div_zero) begin
            w_special_result = w_req_rem ? req_op1 : '1;
        end else begin
            w_special_result = w_req_rem ? '0 : req_op1;
        end
    end

    assign w_last = (r_cnt == CNT_W'(1));

    // Multiplier: add a*digit into the upper half, then shift the whole accumulator right
    // by R so the multiplier bits in the lower half drain as product bits fill in.
    assign w_digit        = r_acc[R-1:0];
    assign w_pp           = (XLEN+R)'(r_a) * (XLEN+R)'(w_digit);
    assign w_sum          = (XLEN+R)'(r_acc[2*XLEN-1:XLEN]) + w_pp;
    assign w_mul_acc_next = {w_sum, r_acc[XLEN-1:R]};
    assign w_prod_fix     = r_neg ? -w_mul_acc_next : w_mul_acc_next;
    assign w_mul_res      = (r_code == CODE_MUL) ? w_prod_fix[XLEN-1:0]
                                                 : w_prod_fix[2*XLEN-1:XLEN];

    muldiv_div_iter #(
        .XLEN      (XLEN)
    ) u_div_iter (
        .i_rem     (r_acc[2*XLEN-1:XLEN]),
        .i_quot    (r_acc[XLEN-1:0]),
        .i_divisor (r_a),
        .o_rem     (w_div_rem),
        .o_quot    (w_div_quot)
    );

    assign w_div_raw = is_rem_op(r_code) ? w_div_rem : w_div_quot;
    assign w_div_res = r_neg ? -w_div_raw : w_div_raw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_special)      w_next_state = ST_DONE;
                        else if (w_req_div) w_next_state = ST_DIV;
                        else                w_next_state = ST_MUL;
                    end
                end
                ST_MUL:  if (w_last) w_next_state = ST_DONE;
                ST_DIV:  if (w_last) w_next_state = ST_DONE;
                ST_DONE: if (resp_ready) w_next_state = ST_IDLE;
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready   = (r_state == ST_IDLE);
        resp_valid  = (r_state == ST_DONE);
        busy        = (r_state != ST_IDLE);
        dbg_state   = r_state;
        resp_result = r_result;
        resp_tag    = r_tag;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_code   <= CODE_MUL;
            r_tag    <= '0;
            r_neg    <= 1'b0;
            r_a      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_code <= w_req_code;
                        r_tag  <= req_tag;
                        // Remainder sign follows the dividend; quotient/product sign is the xor.
                        r_neg  <= w_req_rem ? w_op1_neg : (w_op1_neg ^ w_op2_neg);
                        r_a    <= w_req_div ? w_op2_mag : w_op1_mag;
                        r_acc  <= {{XLEN{1'b0}}, (w_req_div ? w_op1_mag : w_op2_mag)};
                        if (w_special) begin
                            r_cnt    <= '0;
                            r_result <= w_special_result;
                        end else begin
                            r_cnt <= w_req_div ? CNT_W'(XLEN) : CNT_W'(MUL_ITERS);
                        end
                    end
                end
                ST_MUL: begin
                    if (r_cnt != '0) begin
                        r_acc <= w_mul_acc_next;
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (w_last) r_result <= w_mul_res;
                    end
                end
                ST_DIV: begin
                    if (r_cnt != '0) begin
                        r_acc <= {w_div_rem, w_div_quot};
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (w_last) r_result <= w_div_res;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exec_muldiv_unit.sv
// Directed bench for exec_muldiv_unit: a 32-bit/radix-4 instance and a 64-bit/radix-256
// instance share clock, reset and operand buses; a select picks which one a step drives.
module tb_exec_muldiv_unit;
    import exec_muldiv_unit_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        flush;
    logic        resp_ready;
    logic        req_valid32;
    logic        req_valid64;
    logic        sel64;
    logic [2:0]  code;
    logic [63:0] op1;
    logic [63:0] op2;
    logic [4:0]  tag;

    logic        req_ready32, resp_valid32, busy32;
    logic [31:0] result32;
    logic [4:0]  rtag32;
    logic [1:0]  dbg32;
    logic        req_ready64, resp_valid64, busy64;
    logic [63:0] result64;
    logic [4:0]  rtag64;
    logic [1:0]  dbg64;

    logic        m_req_ready, m_resp_valid, m_busy;
    logic [63:0] m_result;
    logic [4:0]  m_tag;

    int n_checks = 0;
    int n_errors = 0;

    exec_muldiv_unit #(.XLEN(32), .MUL_RADIX_BITS(2), .TAG_W(5)) dut32 (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .req_valid   (req_valid32),
        .req_ready   (req_ready32),
        .req_code    (code),
        .req_op1     (op1[31:0]),
        .req_op2     (op2[31:0]),
        .req_tag     (tag),
        .resp_valid  (resp_valid32),
        .resp_ready  (resp_ready),
        .resp_result (result32),
        .resp_tag    (rtag32),
        .busy        (busy32),
        .dbg_state   (dbg32)
    );

    exec_muldiv_unit #(.XLEN(64), .MUL_RADIX_BITS(8), .TAG_W(5)) dut64 (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .req_valid   (req_valid64),
        .req_ready   (req_ready64),
        .req_code    (code),
        .req_op1     (op1),
        .req_op2     (op2),
        .req_tag     (tag),
        .resp_valid  (resp_valid64),
        .resp_ready  (resp_ready),
        .resp_result (result64),
        .resp_tag    (rtag64),
        .busy        (busy64),
        .dbg_state   (dbg64)
    );

    assign m_req_ready  = sel64 ? req_ready64  : req_ready32;
    assign m_resp_valid = sel64 ? resp_valid64 : resp_valid32;
    assign m_busy       = sel64 ? busy64       : busy32;
    assign m_result     = sel64 ? result64     : {32'b0, result32};
    assign m_tag        = sel64 ? rtag64       : rtag32;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic drive_req(input bit w64, input logic [2:0] c, input logic [63:0] a,
                             input logic [63:0] b, input logic [4:0] t);
        sel64 = w64;
        code  = c;
        op1   = a;
        op2   = b;
        tag   = t;
        if (w64) req_valid64 = 1'b1;
        else     req_valid32 = 1'b1;
    endtask

    task automatic check_idle(input string name);
        check({name, " idle req_ready"}, 64'(m_req_ready), 64'd1);
        check({name, " idle resp_valid"}, 64'(m_resp_valid), 64'd0);
        check({name, " idle busy"}, 64'(m_busy), 64'd0);
    endtask

    // Called at a negedge with the unit idle; returns at a negedge with the unit idle again.
    task automatic do_op(input string name, input bit w64, input logic [2:0] c,
                         input logic [63:0] a, input logic [63:0] b, input logic [4:0] t,
                         input logic [63:0] exp, input int exp_lat, input int hold);
        int lat;
        resp_ready = (hold == 0);
        drive_req(w64, c, a, b, t);
        @(posedge clk);
        @(negedge clk);
        req_valid32 = 1'b0;
        req_valid64 = 1'b0;
        lat = 1;
        while (!m_resp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " result"}, m_result, exp);
        check({name, " tag"}, 64'(m_tag), 64'(t));
        if (hold > 0) begin
            drive_req(w64, CODE_MUL, 64'd3, 64'd4, ~t);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check({name, " stall valid"}, 64'(m_resp_valid), 64'd1);
                check({name, " stall result"}, m_result, exp);
                check({name, " stall tag"}, 64'(m_tag), 64'(t));
                check({name, " stall req_ready"}, 64'(m_req_ready), 64'd0);
            end
            resp_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid32 = 1'b0;
        req_valid64 = 1'b0;
        check_idle(name);
    endtask

    initial begin
        int seen;
        rst         = 1'b1;
        flush       = 1'b0;
        resp_ready  = 1'b1;
        req_valid32 = 1'b0;
        req_valid64 = 1'b0;
        sel64       = 1'b0;
        code        = CODE_MUL;
        op1         = '0;
        op2         = '0;
        tag         = '0;
        repeat (2) @(negedge clk);

        check("reset req_ready32", 64'(req_ready32), 64'd1);
        check("reset resp_valid32", 64'(resp_valid32), 64'd0);
        check("reset result32", 64'(result32), 64'd0);
        check("reset tag32", 64'(rtag32), 64'd0);
        check("reset busy32", 64'(busy32), 64'd0);
        check("reset state32", 64'(dbg32), 64'd0);
        check("reset result64", result64, 64'd0);
        check("reset busy64", 64'(busy64), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op("mul 7*-3",      0, CODE_MUL,    64'd7, 64'hFFFFFFFD, 5'd5, 64'hFFFFFFEB, 17, 0);
        do_op("mulhu max*max", 0, CODE_MULHU,  64'hFFFFFFFF, 64'hFFFFFFFF, 5'd6, 64'hFFFFFFFE, 17, 0);
        do_op("mulhsu -1*2",   0, CODE_MULHSU, 64'hFFFFFFFF, 64'd2, 5'd7, 64'hFFFFFFFF, 17, 0);
        do_op("mulh -1*-1",    0, CODE_MULH,   64'hFFFFFFFF, 64'hFFFFFFFF, 5'd8, 64'd0, 17, 0);
        do_op("mulh min*min",  0, CODE_MULH,   64'h80000000, 64'h80000000, 5'd9, 64'h40000000, 17, 0);
        do_op("mulhu 7fff^2",  0, CODE_MULHU,  64'h7FFFFFFF, 64'h7FFFFFFF, 5'd10, 64'h3FFFFFFF, 17, 0);
        do_op("div -7/2",      0, CODE_DIV,    64'hFFFFFFF9, 64'd2, 5'd11, 64'hFFFFFFFD, 33, 0);
        do_op("rem -7/2",      0, CODE_REM,    64'hFFFFFFF9, 64'd2, 5'd12, 64'hFFFFFFFF, 33, 0);
        do_op("div 7/-2",      0, CODE_DIV,    64'd7, 64'hFFFFFFFE, 5'd13, 64'hFFFFFFFD, 33, 0);
        do_op("rem 7/-2",      0, CODE_REM,    64'd7, 64'hFFFFFFFE, 5'd14, 64'd1, 33, 0);
        do_op("divu 100/7",    0, CODE_DIVU,   64'd100, 64'd7, 5'd15, 64'd14, 33, 0);
        do_op("remu 100/7",    0, CODE_REMU,   64'd100, 64'd7, 5'd16, 64'd2, 33, 0);
        do_op("div x/0",       0, CODE_DIV,    64'd1234, 64'd0, 5'd17, 64'hFFFFFFFF, 1, 0);
        do_op("remu 5/0",      0, CODE_REMU,   64'd5, 64'd0, 5'd18, 64'd5, 1, 0);
        do_op("div ovf",       0, CODE_DIV,    64'h80000000, 64'hFFFFFFFF, 5'd19, 64'h80000000, 1, 0);
        do_op("rem ovf",       0, CODE_REM,    64'h80000000, 64'hFFFFFFFF, 5'd20, 64'd0, 1, 0);

        do_op("stall divu",    0, CODE_DIVU,   64'd100, 64'd7, 5'd21, 64'd14, 33, 10);

        // Flush in the fifth DIV cycle: no response must ever appear.
        resp_ready = 1'b1;
        drive_req(0, CODE_DIVU, 64'd100, 64'd7, 5'd22);
        @(posedge clk);
        @(negedge clk);
        req_valid32 = 1'b0;
        repeat (4) @(negedge clk);
        check("flush div busy before", 64'(busy32), 64'd1);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check_idle("flush div");
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp_valid32) seen++;
        end
        check("flush div no resp", 64'(seen), 64'd0);
        do_op("after flush divu", 0, CODE_DIVU, 64'd100, 64'd7, 5'd23, 64'd14, 33, 0);

        // Flush coincident with a request: the request is dropped.
        flush = 1'b1;
        drive_req(0, CODE_MUL, 64'd7, 64'hFFFFFFFD, 5'd24);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        req_valid32 = 1'b0;
        check_idle("flush req");
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (resp_valid32 || busy32) seen++;
        end
        check("flush req no activity", 64'(seen), 64'd0);
        do_op("after flush mul", 0, CODE_MUL, 64'd7, 64'hFFFFFFFD, 5'd25, 64'hFFFFFFEB, 17, 0);

        // Flush while a result waits in DONE: it is withdrawn.
        resp_ready = 1'b0;
        drive_req(0, CODE_DIVU, 64'd9, 64'd0, 5'd26);
        @(posedge clk);
        @(negedge clk);
        req_valid32 = 1'b0;
        check("flush done valid before", 64'(resp_valid32), 64'd1);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        resp_ready = 1'b1;
        check_idle("flush done");

        // Asynchronous reset in the middle of a multiply.
        drive_req(0, CODE_MUL, 64'd7, 64'd9, 5'd3);
        @(posedge clk);
        @(negedge clk);
        req_valid32 = 1'b0;
        repeat (4) @(negedge clk);
        check("mid mul busy", 64'(busy32), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("async rst result", 64'(result32), 64'd0);
        check("async rst tag", 64'(rtag32), 64'd0);
        check("async rst busy", 64'(busy32), 64'd0);
        check("async rst req_ready", 64'(req_ready32), 64'd1);
        check("async rst resp_valid", 64'(resp_valid32), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_op("after rst mul", 0, CODE_MUL, 64'd7, 64'd9, 5'd4, 64'd63, 17, 0);

        do_op("x64 mul 7*-3",    1, CODE_MUL,    64'd7, 64'hFFFFFFFFFFFFFFFD, 5'd5,
              64'hFFFFFFFFFFFFFFEB, 9, 0);
        do_op("x64 mulhu max",   1, CODE_MULHU,  64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 5'd6,
              64'hFFFFFFFFFFFFFFFE, 9, 0);
        do_op("x64 mulhsu -1*2", 1, CODE_MULHSU, 64'hFFFFFFFFFFFFFFFF, 64'd2, 5'd7,
              64'hFFFFFFFFFFFFFFFF, 9, 0);
        do_op("x64 mulh -1*-1",  1, CODE_MULH,   64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 5'd8,
              64'd0, 9, 0);
        do_op("x64 div -7/2",    1, CODE_DIV,    64'hFFFFFFFFFFFFFFF9, 64'd2, 5'd9,
              64'hFFFFFFFFFFFFFFFD, 65, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
